// File: rtl/bbm_pkg.sv
// bbm_pkg: shared definitions for the multiphase break-before-make driver.
//   state_t   - per-phase FSM state encoding
//   *_DEF     - default values for the NPH / DTW / TOW parameters
package bbm_pkg;

  localparam int NPH_DEF = 2;  // number of top/bottom switch phases
  localparam int DTW_DEF = 6;  // dead-time counter width
  localparam int TOW_DEF = 8;  // turn-off timeout counter width

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TOP      = 3'd1,
    S_BOT      = 3'd2,
    S_WAIT_OFF = 3'd3,
    S_DEAD     = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

endpackage

// File: rtl/bbm_phase.sv
// bbm_phase: break-before-make sequencer for one top/bottom switch pair.
//   clk, rst_n         - clock, async active-low reset (already synchronised on release)
//   enable             - global enable; low drives the target to off
//   top_req, bot_req   - switch requests (both high = off + req_err)
//   top_st, bot_st     - switch conducting feedback
//   fault_clr          - level clear for the sticky timeout fault
//   dt_cfg, to_cfg     - dead time / turn-off timeout in cycles (0 = no timeout)
//   top_on, bot_on     - registered switch drives, never both high
//   fault              - sticky turn-off timeout flag
//   req_err            - high the cycle after both requests were sampled high
module bbm_phase
  import bbm_pkg::*;
#(
  parameter int DTW = DTW_DEF,
  parameter int TOW = TOW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           top_req,
  input  logic           bot_req,
  input  logic           top_st,
  input  logic           bot_st,
  input  logic           fault_clr,
  input  logic [DTW-1:0] dt_cfg,
  input  logic [TOW-1:0] to_cfg,
  output logic           top_on,
  output logic           bot_on,
  output logic           fault,
  output logic           req_err
);

  // One counter serves both the timeout (WAIT_OFF) and dead time (DEAD).
  localparam int CW = (DTW > TOW) ? DTW : TOW;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rel_top;   // switch released on entry to WAIT_OFF: 1 = top
  logic          tgt_top;
  logic          tgt_bot;
  logic          rel_st;

  // Disable folds into the target: active states see "off" and release,
  // WAIT_OFF/DEAD finish their sequence and DEAD then exits to IDLE.
  assign tgt_top = enable & top_req & ~bot_req;
  assign tgt_bot = enable & bot_req & ~top_req;
  assign rel_st  = rel_top ? top_st : bot_st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rel_top <= 1'b0;
      top_on  <= 1'b0;
      bot_on  <= 1'b0;
      fault   <= 1'b0;
      req_err <= 1'b0;
    end else begin
      req_err <= top_req & bot_req;
      case (state)
        S_IDLE: begin
          if (tgt_top && !bot_st) begin
            state  <= S_TOP;
            top_on <= 1'b1;
          end else if (tgt_bot && !top_st) begin
            state  <= S_BOT;
            bot_on <= 1'b1;
          end
        end
        S_TOP: begin
          if (!tgt_top) begin
            state   <= S_WAIT_OFF;
            top_on  <= 1'b0;
            rel_top <= 1'b1;
            cnt     <= CW'(to_cfg);
          end
        end
        S_BOT: begin
          if (!tgt_bot) begin
            state   <= S_WAIT_OFF;
            bot_on  <= 1'b0;
            rel_top <= 1'b0;
            cnt     <= CW'(to_cfg);
          end
        end
        S_WAIT_OFF: begin
          // cnt == 0 here only when to_cfg was 0: timeout disabled.
          if (!rel_st) begin
            state <= S_DEAD;
            cnt   <= CW'(dt_cfg);
          end else if (cnt == CW'(1)) begin
            state <= S_FAULT;
            fault <= 1'b1;
            cnt   <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DEAD: begin
          // Target is only looked at here; the opposite status is still
          // checked so a drive never rises onto a conducting partner.
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (tgt_top && !bot_st) begin
            state  <= S_TOP;
            top_on <= 1'b1;
          end else if (tgt_bot && !top_st) begin
            state  <= S_BOT;
            bot_on <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_FAULT: begin
          if (fault_clr && !top_st && !bot_st) begin
            state <= S_IDLE;
            fault <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          top_on <= 1'b0;
          bot_on <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bbm_multiphase.sv
// bbm_multiphase: NPH independent break-before-make switch-pair drivers.
//   clk, rst_n                 - clock, async-assert active-low reset
//   enable_driver              - global enable; low turns every phase off
//   topstate/botstate [NPH]    - per-phase switch requests
//   topswstatus/botswstatus    - per-phase conducting feedback
//   dt_cfg, to_cfg             - shared dead time / turn-off timeout
//   fault_clr [NPH]            - per-phase sticky-fault clear
//   topswon/botswon [NPH]      - registered switch drives
//   fault, req_err [NPH]       - timeout flag, both-requested pulse
module bbm_multiphase
  import bbm_pkg::*;
#(
  parameter int NPH = NPH_DEF,
  parameter int DTW = DTW_DEF,
  parameter int TOW = TOW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable_driver,
  input  logic [NPH-1:0] topstate,
  input  logic [NPH-1:0] botstate,
  input  logic [NPH-1:0] topswstatus,
  input  logic [NPH-1:0] botswstatus,
  input  logic [DTW-1:0] dt_cfg,
  input  logic [TOW-1:0] to_cfg,
  input  logic [NPH-1:0] fault_clr,
  output logic [NPH-1:0] topswon,
  output logic [NPH-1:0] botswon,
  output logic [NPH-1:0] fault,
  output logic [NPH-1:0] req_err
);

  // Asserts immediately, releases after two clk edges so no phase flop
  // sees a reset edge near the clock.
  logic [1:0] rst_sync;
  logic       prst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign prst_n = rst_sync[1];

  for (genvar g = 0; g < NPH; g++) begin : g_ph
    bbm_phase #(.DTW(DTW), .TOW(TOW)) u_phase (
      .clk       (clk),
      .rst_n     (prst_n),
      .enable    (enable_driver),
      .top_req   (topstate[g]),
      .bot_req   (botstate[g]),
      .top_st    (topswstatus[g]),
      .bot_st    (botswstatus[g]),
      .fault_clr (fault_clr[g]),
      .dt_cfg    (dt_cfg),
      .to_cfg    (to_cfg),
      .top_on    (topswon[g]),
      .bot_on    (botswon[g]),
      .fault     (fault[g]),
      .req_err   (req_err[g])
    );
  end

endmodule

// File: tb/tb_bbm_multiphase.sv
// tb_bbm_multiphase: scenario tasks for bbm_multiphase (NPH=4 so the random
// phase-independence run shares the instance with the directed scenarios,
// which use phases 0..2). Expected output vectors are pushed to sbq when
// stimulus is applied and popped after the edge.
module tb_bbm_multiphase;
  localparam int NPH = 4;
  localparam int DTW = 6;
  localparam int TOW = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enable_driver;
  logic [NPH-1:0] topstate, botstate, topswstatus, botswstatus, fault_clr;
  logic [DTW-1:0] dt_cfg;
  logic [TOW-1:0] to_cfg;
  logic [NPH-1:0] topswon, botswon, fault, req_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string          tag;
    logic [NPH-1:0] top;
    logic [NPH-1:0] bot;
    logic [NPH-1:0] flt;
    logic [NPH-1:0] rerr;
  } exp_t;
  exp_t sbq[$];

  bbm_multiphase #(.NPH(NPH), .DTW(DTW), .TOW(TOW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_driver (enable_driver),
    .topstate      (topstate),
    .botstate      (botstate),
    .topswstatus   (topswstatus),
    .botswstatus   (botswstatus),
    .dt_cfg        (dt_cfg),
    .to_cfg        (to_cfg),
    .fault_clr     (fault_clr),
    .topswon       (topswon),
    .botswon       (botswon),
    .fault         (fault),
    .req_err       (req_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    assert (!(|(topswon & botswon)))
      else $error("FAIL overlap: top=%b bot=%b", topswon, botswon);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    int   n;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) topstate[0] = 1'b1;   // request during reset must be ignored
      if (c == 4) rst_n = 1'b1;         // first edge after release: still off
      sbq.push_back('{"reset", 4'b0, 4'b0, 4'b0, 4'b0});
      tick();
      e = sbq.pop_front();
      total++;
      if (topswon !== e.top || botswon !== e.bot || fault !== e.flt || req_err !== e.rerr) begin
        bad++;
        $display("FAIL %s c=%0d: got top=%b bot=%b flt=%b rerr=%b want top=%b bot=%b flt=%b rerr=%b",
                 e.tag, c, topswon, botswon, fault, req_err, e.top, e.bot, e.flt, e.rerr);
      end
    end
    n = 0;
    while (topswon[0] !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    total++;
    if (topswon !== 4'b0001 || botswon !== 4'b0000) begin
      bad++;
      $display("FAIL reset_release: got top=%b bot=%b want top=0001 bot=0000 within 5 edges",
               topswon, botswon);
    end
    topswstatus[0] = 1'b1;
  endtask

  // Phase0 TOP -> off with top status stuck high: fault after 10 cycles in
  // WAIT_OFF; to_cfg change mid-count ignored; clear needs statuses low.
  task automatic test_timeout();
    exp_t e;
    for (int c = 0; c <= 13; c++) begin
      if (c == 0)  topstate[0] = 1'b0;
      if (c == 1)  to_cfg = 8'd2;
      if (c == 11) fault_clr[0] = 1'b1;
      if (c == 13) topswstatus[0] = 1'b0;
      sbq.push_back('{"timeout", 4'b0, 4'b0, NPH'(c >= 10 && c < 13), 4'b0});
      tick();
      e = sbq.pop_front();
      total++;
      if (topswon !== e.top || botswon !== e.bot || fault !== e.flt || req_err !== e.rerr) begin
        bad++;
        $display("FAIL %s c=%0d: got top=%b bot=%b flt=%b rerr=%b want top=%b bot=%b flt=%b rerr=%b",
                 e.tag, c, topswon, botswon, fault, req_err, e.top, e.bot, e.flt, e.rerr);
      end
    end
    fault_clr[0] = 1'b0;
    to_cfg = 8'd10;
  endtask

  // Phase0 IDLE -> TOP (1-cycle latency), then TOP -> BOT with dt_cfg=4.
  // Top status drops 2 cycles after topswon falls; the first edge sampling
  // it low enters DEAD, botswon rises dt_cfg+1 = 5 edges later.
  task automatic test_deadtime();
    exp_t e;
    dt_cfg = 6'd4;
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) topstate[0] = 1'b1;
      if (c == 1) topswstatus[0] = 1'b1;
      if (c == 2) begin topstate[0] = 1'b0; botstate[0] = 1'b1; end
      if (c == 4) topswstatus[0] = 1'b0;
      if (c == 5) dt_cfg = 6'd20;        // mid-count change ignored
      if (c == 10) begin botswstatus[0] = 1'b1; dt_cfg = 6'd4; end
      sbq.push_back('{"deadtime", NPH'(c <= 1), NPH'(c >= 9), 4'b0, 4'b0});
      tick();
      e = sbq.pop_front();
      total++;
      if (topswon !== e.top || botswon !== e.bot || fault !== e.flt || req_err !== e.rerr) begin
        bad++;
        $display("FAIL %s c=%0d: got top=%b bot=%b flt=%b rerr=%b want top=%b bot=%b flt=%b rerr=%b",
                 e.tag, c, topswon, botswon, fault, req_err, e.top, e.bot, e.flt, e.rerr);
      end
    end
  endtask

  task automatic test_req_err();
    exp_t e;
    for (int c = 0; c <= 2; c++) begin
      if (c == 0) begin topstate[1] = 1'b1; botstate[1] = 1'b1; end
      if (c == 1) begin topstate[1] = 1'b0; botstate[1] = 1'b0; end
      sbq.push_back('{"req_err", 4'b0, 4'b0001, 4'b0, (c == 0) ? 4'b0010 : 4'b0000});
      tick();
      e = sbq.pop_front();
      total++;
      if (topswon !== e.top || botswon !== e.bot || fault !== e.flt || req_err !== e.rerr) begin
        bad++;
        $display("FAIL %s c=%0d: got top=%b bot=%b flt=%b rerr=%b want top=%b bot=%b flt=%b rerr=%b",
                 e.tag, c, topswon, botswon, fault, req_err, e.top, e.bot, e.flt, e.rerr);
      end
    end
  endtask

  // Phase1 driven into FAULT (to_cfg=3) while phase0 sits in BOT; enable
  // low then drops botswon[0] at the next edge and keeps fault[1].
  task automatic test_enable_off();
    exp_t e;
    to_cfg = 8'd3;
    for (int c = 0; c <= 13; c++) begin
      if (c == 0) topstate[1] = 1'b1;
      if (c == 1) begin topswstatus[1] = 1'b1; topstate[1] = 1'b0; end
      if (c == 5) enable_driver = 1'b0;
      if (c == 6) begin topswstatus[1] = 1'b0; botswstatus[0] = 1'b0; end
      if (c == 12) fault_clr[1] = 1'b1;
      sbq.push_back('{"enable_off", (c == 0) ? 4'b0010 : 4'b0000, NPH'(c < 5),
                      (c >= 4 && c < 12) ? 4'b0010 : 4'b0000, 4'b0});
      tick();
      e = sbq.pop_front();
      total++;
      if (topswon !== e.top || botswon !== e.bot || fault !== e.flt || req_err !== e.rerr) begin
        bad++;
        $display("FAIL %s c=%0d: got top=%b bot=%b flt=%b rerr=%b want top=%b bot=%b flt=%b rerr=%b",
                 e.tag, c, topswon, botswon, fault, req_err, e.top, e.bot, e.flt, e.rerr);
      end
    end
    fault_clr[1] = 1'b0;
    botstate[0] = 1'b0;
    enable_driver = 1'b1;
    to_cfg = 8'd10;
  endtask

  // Phase0 in a long DEAD, phase2 in TOP; reset mid-cycle clears outputs
  // without a clock edge and phase0 restarts from IDLE, not the old count.
  task automatic test_reset_mid_dead();
    exp_t e;
    int   n;
    dt_cfg = 6'd10;
    for (int c = 0; c <= 3; c++) begin
      if (c == 0) begin topstate[0] = 1'b1; topstate[2] = 1'b1; end
      if (c == 1) topstate[0] = 1'b0;
      sbq.push_back('{"pre_reset", (c == 0) ? 4'b0101 : 4'b0100, 4'b0, 4'b0, 4'b0});
      tick();
      e = sbq.pop_front();
      total++;
      if (topswon !== e.top || botswon !== e.bot || fault !== e.flt || req_err !== e.rerr) begin
        bad++;
        $display("FAIL %s c=%0d: got top=%b bot=%b flt=%b rerr=%b want top=%b bot=%b flt=%b rerr=%b",
                 e.tag, c, topswon, botswon, fault, req_err, e.top, e.bot, e.flt, e.rerr);
      end
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (topswon !== 4'b0 || botswon !== 4'b0 || fault !== 4'b0 || req_err !== 4'b0) begin
      bad++;
      $display("FAIL async_reset: got top=%b bot=%b flt=%b rerr=%b want all 0",
               topswon, botswon, fault, req_err);
    end
    tick();
    botstate[0] = 1'b1;
    rst_n = 1'b1;
    tick();
    total++;
    if (botswon !== 4'b0 || topswon !== 4'b0) begin
      bad++;
      $display("FAIL reset_first_edge: got top=%b bot=%b want 0000 0000", topswon, botswon);
    end
    n = 0;
    while (botswon[0] !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    total++;
    if (botswon[0] !== 1'b1 || topswon[0] !== 1'b0) begin
      bad++;
      $display("FAIL restart_idle: got top0=%b bot0=%b want top0=0 bot0=1 within 5 edges",
               topswon[0], botswon[0]);
    end
    botstate = '0;
    topstate = '0;
    dt_cfg = 6'd4;
    repeat (10) tick();
  endtask

  // Random requests with switch feedback that follows the drives after a
  // random delay; dt=0, timeout disabled. Every phase every cycle: no
  // overlap, and a rising drive had its partner's status low at that edge.
  task automatic test_random();
    logic [NPH-1:0] tpre, bpre, tst, bst;
    dt_cfg = 6'd0;
    to_cfg = 8'd0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) topstate = NPH'($urandom);
      if ($urandom_range(0, 7) == 0) botstate = NPH'($urandom);
      enable_driver = ($urandom_range(0, 31) != 0);
      for (int i = 0; i < NPH; i++) begin
        if (topswstatus[i] != topswon[i] && $urandom_range(0, 2) == 0) topswstatus[i] = topswon[i];
        if (botswstatus[i] != botswon[i] && $urandom_range(0, 2) == 0) botswstatus[i] = botswon[i];
      end
      tpre = topswon;
      bpre = botswon;
      tst  = topswstatus;
      bst  = botswstatus;
      tick();
      for (int i = 0; i < NPH; i++) begin
        total++;
        if ((topswon[i] && botswon[i]) ||
            (topswon[i] && !tpre[i] && bst[i]) ||
            (botswon[i] && !bpre[i] && tst[i]) || fault[i] !== 1'b0) begin
          bad++;
          $display("FAIL random c=%0d ph=%0d: got top=%b bot=%b flt=%b (prev top=%b bot=%b, st top=%b bot=%b) want no overlap, partner off on rise, no fault",
                   c, i, topswon[i], botswon[i], fault[i], tpre[i], bpre[i], tst[i], bst[i]);
        end
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    enable_driver = 1'b1;
    topstate      = '0;
    botstate      = '0;
    topswstatus   = '0;
    botswstatus   = '0;
    fault_clr     = '0;
    dt_cfg        = 6'd4;
    to_cfg        = 8'd10;
    test_reset();
    test_timeout();
    test_deadtime();
    test_req_err();
    test_enable_off();
    test_reset_mid_dead();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
